// File: rtl/axi_outstanding_limiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_outstanding_limiter
// Description : Transparent AXI4 limiter sitting between a kernel master and
//               the axi_pipeline. It counts accepted read and write bursts and
//               closes the AR / AW address gates when the number in flight
//               reaches MAX_RD_OUTSTANDING / MAX_WR_OUTSTANDING.
//               Payload, W, B and R signals pass through combinationally.
// Ports       : ap_clk, ap_rst_n    - clock, async active-low reset
//               in_AW/W/B/AR/R*     - slave side, from the kernel
//               out_AW/W/B/AR/R*    - master side, to axi_pipeline in_*
//               rd_outstanding      - read bursts awaiting their RLAST beat
//               wr_outstanding      - write bursts awaiting their B response
//               idle                - both counters are zero
//               err                 - sticky counter-underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module axi_outstanding_limiter #(
  parameter int C_M_AXI_ID_WIDTH    = 8,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_M_AXI_WSTRB_WIDTH = 64,
  parameter int MAX_RD_OUTSTANDING  = 16,
  parameter int MAX_WR_OUTSTANDING  = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  // kernel-side write address
  input  logic                           in_AWVALID,
  output logic                           in_AWREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_AWADDR,
  input  logic [1:0]                     in_AWBURST,
  input  logic [7:0]                     in_AWLEN,
  input  logic [2:0]                     in_AWSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_AWID,
  // kernel-side write data
  input  logic                           in_WVALID,
  output logic                           in_WREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  in_WDATA,
  input  logic [C_M_AXI_WSTRB_WIDTH-1:0] in_WSTRB,
  input  logic                           in_WLAST,
  // kernel-side write response
  output logic                           in_BVALID,
  input  logic                           in_BREADY,
  output logic [1:0]                     in_BRESP,
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_BID,
  // kernel-side read address
  input  logic                           in_ARVALID,
  output logic                           in_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_ARADDR,
  input  logic [1:0]                     in_ARBURST,
  input  logic [7:0]                     in_ARLEN,
  input  logic [2:0]                     in_ARSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_ARID,
  // kernel-side read data
  output logic                           in_RVALID,
  input  logic                           in_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  in_RDATA,
  output logic                           in_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_RID,
  output logic [1:0]                     in_RRESP,
  // pipeline-side write address
  output logic                           out_AWVALID,
  input  logic                           out_AWREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_AWADDR,
  output logic [1:0]                     out_AWBURST,
  output logic [7:0]                     out_AWLEN,
  output logic [2:0]                     out_AWSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_AWID,
  // pipeline-side write data
  output logic                           out_WVALID,
  input  logic                           out_WREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  out_WDATA,
  output logic [C_M_AXI_WSTRB_WIDTH-1:0] out_WSTRB,
  output logic                           out_WLAST,
  // pipeline-side write response
  input  logic                           out_BVALID,
  output logic                           out_BREADY,
  input  logic [1:0]                     out_BRESP,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_BID,
  // pipeline-side read address
  output logic                           out_ARVALID,
  input  logic                           out_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_ARADDR,
  output logic [1:0]                     out_ARBURST,
  output logic [7:0]                     out_ARLEN,
  output logic [2:0]                     out_ARSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_ARID,
  // pipeline-side read data
  input  logic                           out_RVALID,
  output logic                           out_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  out_RDATA,
  input  logic                           out_RLAST,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_RID,
  input  logic [1:0]                     out_RRESP,
  // status
  output logic [7:0]                     rd_outstanding,
  output logic [7:0]                     wr_outstanding,
  output logic                           idle,
  output logic                           err
);

  localparam logic [7:0] c_MAX_RD = 8'(MAX_RD_OUTSTANDING);
  localparam logic [7:0] c_MAX_WR = 8'(MAX_WR_OUTSTANDING);

  logic [7:0] r_rd_cnt;
  logic [7:0] r_wr_cnt;
  logic       r_err;

  // Full flags come from registered counts only, so READY never depends
  // combinationally on any VALID and a same-cycle completion cannot reopen
  // the gate until the counter has actually moved.
  logic w_rd_full;
  logic w_wr_full;
  logic w_ar_hs;
  logic w_rlast_hs;
  logic w_aw_hs;
  logic w_b_hs;

  assign w_rd_full = (r_rd_cnt == c_MAX_RD);
  assign w_wr_full = (r_wr_cnt == c_MAX_WR);

  // Gated address channels
  assign out_AWVALID = in_AWVALID & ~w_wr_full;
  assign in_AWREADY  = out_AWREADY & ~w_wr_full;
  assign out_ARVALID = in_ARVALID & ~w_rd_full;
  assign in_ARREADY  = out_ARREADY & ~w_rd_full;

  // Address payloads
  assign out_AWADDR  = in_AWADDR;
  assign out_AWBURST = in_AWBURST;
  assign out_AWLEN   = in_AWLEN;
  assign out_AWSIZE  = in_AWSIZE;
  assign out_AWID    = in_AWID;
  assign out_ARADDR  = in_ARADDR;
  assign out_ARBURST = in_ARBURST;
  assign out_ARLEN   = in_ARLEN;
  assign out_ARSIZE  = in_ARSIZE;
  assign out_ARID    = in_ARID;

  // W may lead AW, so the write-data channel is never gated.
  assign out_WVALID  = in_WVALID;
  assign in_WREADY   = out_WREADY;
  assign out_WDATA   = in_WDATA;
  assign out_WSTRB   = in_WSTRB;
  assign out_WLAST   = in_WLAST;

  assign in_BVALID   = out_BVALID;
  assign out_BREADY  = in_BREADY;
  assign in_BRESP    = out_BRESP;
  assign in_BID      = out_BID;

  assign in_RVALID   = out_RVALID;
  assign out_RREADY  = in_RREADY;
  assign in_RDATA    = out_RDATA;
  assign in_RLAST    = out_RLAST;
  assign in_RID      = out_RID;
  assign in_RRESP    = out_RRESP;

  // Handshake events
  assign w_ar_hs    = out_ARVALID & out_ARREADY;
  assign w_rlast_hs = in_RVALID & in_RREADY & in_RLAST;
  assign w_aw_hs    = out_AWVALID & out_AWREADY;
  assign w_b_hs     = in_BVALID & in_BREADY;

  // Counters. An increment and a completion in the same cycle cancel out.
  // A lone completion at zero holds the counter and flags underflow.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_ar_hs && !w_rlast_hs) begin
        r_rd_cnt <= r_rd_cnt + 8'd1;
      end else if (w_rlast_hs && !w_ar_hs) begin
        if (r_rd_cnt == 8'd0) r_err <= 1'b1;
        else                  r_rd_cnt <= r_rd_cnt - 8'd1;
      end

      if (w_aw_hs && !w_b_hs) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end else if (w_b_hs && !w_aw_hs) begin
        if (r_wr_cnt == 8'd0) r_err <= 1'b1;
        else                  r_wr_cnt <= r_wr_cnt - 8'd1;
      end
    end
  end

  assign rd_outstanding = r_rd_cnt;
  assign wr_outstanding = r_wr_cnt;
  assign idle           = (r_rd_cnt == 8'd0) && (r_wr_cnt == 8'd0);
  assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_outstanding_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_outstanding_limiter
// Description : Directed self-checking bench for axi_outstanding_limiter with
//               MAX_RD = MAX_WR = 4, followed by a short random-stall phase
//               tracked by a bench-side burst-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_outstanding_limiter;

  localparam int c_IDW = 4;
  localparam int c_AW  = 32;
  localparam int c_DW  = 32;
  localparam int c_SW  = 4;
  localparam int c_MAX = 4;

  logic ap_clk, ap_rst_n;
  logic in_AWVALID, in_AWREADY; logic [c_AW-1:0] in_AWADDR; logic [1:0] in_AWBURST;
  logic [7:0] in_AWLEN; logic [2:0] in_AWSIZE; logic [c_IDW-1:0] in_AWID;
  logic in_WVALID, in_WREADY; logic [c_DW-1:0] in_WDATA; logic [c_SW-1:0] in_WSTRB; logic in_WLAST;
  logic in_BVALID, in_BREADY; logic [1:0] in_BRESP; logic [c_IDW-1:0] in_BID;
  logic in_ARVALID, in_ARREADY; logic [c_AW-1:0] in_ARADDR; logic [1:0] in_ARBURST;
  logic [7:0] in_ARLEN; logic [2:0] in_ARSIZE; logic [c_IDW-1:0] in_ARID;
  logic in_RVALID, in_RREADY; logic [c_DW-1:0] in_RDATA; logic in_RLAST;
  logic [c_IDW-1:0] in_RID; logic [1:0] in_RRESP;
  logic out_AWVALID, out_AWREADY; logic [c_AW-1:0] out_AWADDR; logic [1:0] out_AWBURST;
  logic [7:0] out_AWLEN; logic [2:0] out_AWSIZE; logic [c_IDW-1:0] out_AWID;
  logic out_WVALID, out_WREADY; logic [c_DW-1:0] out_WDATA; logic [c_SW-1:0] out_WSTRB; logic out_WLAST;
  logic out_BVALID, out_BREADY; logic [1:0] out_BRESP; logic [c_IDW-1:0] out_BID;
  logic out_ARVALID, out_ARREADY; logic [c_AW-1:0] out_ARADDR; logic [1:0] out_ARBURST;
  logic [7:0] out_ARLEN; logic [2:0] out_ARSIZE; logic [c_IDW-1:0] out_ARID;
  logic out_RVALID, out_RREADY; logic [c_DW-1:0] out_RDATA; logic out_RLAST;
  logic [c_IDW-1:0] out_RID; logic [1:0] out_RRESP;
  logic [7:0] rd_outstanding, wr_outstanding;
  logic idle, err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_outstanding_limiter #(
    .C_M_AXI_ID_WIDTH(c_IDW), .C_M_AXI_ADDR_WIDTH(c_AW), .C_M_AXI_DATA_WIDTH(c_DW),
    .C_M_AXI_WSTRB_WIDTH(c_SW), .MAX_RD_OUTSTANDING(c_MAX), .MAX_WR_OUTSTANDING(c_MAX)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_AWVALID(in_AWVALID), .in_AWREADY(in_AWREADY), .in_AWADDR(in_AWADDR), .in_AWBURST(in_AWBURST),
    .in_AWLEN(in_AWLEN), .in_AWSIZE(in_AWSIZE), .in_AWID(in_AWID),
    .in_WVALID(in_WVALID), .in_WREADY(in_WREADY), .in_WDATA(in_WDATA), .in_WSTRB(in_WSTRB), .in_WLAST(in_WLAST),
    .in_BVALID(in_BVALID), .in_BREADY(in_BREADY), .in_BRESP(in_BRESP), .in_BID(in_BID),
    .in_ARVALID(in_ARVALID), .in_ARREADY(in_ARREADY), .in_ARADDR(in_ARADDR), .in_ARBURST(in_ARBURST),
    .in_ARLEN(in_ARLEN), .in_ARSIZE(in_ARSIZE), .in_ARID(in_ARID),
    .in_RVALID(in_RVALID), .in_RREADY(in_RREADY), .in_RDATA(in_RDATA), .in_RLAST(in_RLAST),
    .in_RID(in_RID), .in_RRESP(in_RRESP),
    .out_AWVALID(out_AWVALID), .out_AWREADY(out_AWREADY), .out_AWADDR(out_AWADDR), .out_AWBURST(out_AWBURST),
    .out_AWLEN(out_AWLEN), .out_AWSIZE(out_AWSIZE), .out_AWID(out_AWID),
    .out_WVALID(out_WVALID), .out_WREADY(out_WREADY), .out_WDATA(out_WDATA), .out_WSTRB(out_WSTRB),
    .out_WLAST(out_WLAST),
    .out_BVALID(out_BVALID), .out_BREADY(out_BREADY), .out_BRESP(out_BRESP), .out_BID(out_BID),
    .out_ARVALID(out_ARVALID), .out_ARREADY(out_ARREADY), .out_ARADDR(out_ARADDR), .out_ARBURST(out_ARBURST),
    .out_ARLEN(out_ARLEN), .out_ARSIZE(out_ARSIZE), .out_ARID(out_ARID),
    .out_RVALID(out_RVALID), .out_RREADY(out_RREADY), .out_RDATA(out_RDATA), .out_RLAST(out_RLAST),
    .out_RID(out_RID), .out_RRESP(out_RRESP),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .idle(idle), .err(err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One R-last handshake per cycle for n cycles, starting at the current negedge.
  task automatic rlast_cycles(input int n);
    out_RVALID = 1'b1; out_RLAST = 1'b1; in_RREADY = 1'b1;
    repeat (n) @(negedge ap_clk);
    out_RVALID = 1'b0; out_RLAST = 1'b0;
  endtask

  int  accepted;
  int  rmodel, wmodel;
  bit  ar_hs, r_hs, aw_hs, b_hs;

  initial begin
    ap_rst_n = 1'b0;
    {in_AWVALID, in_AWADDR, in_AWBURST, in_AWLEN, in_AWSIZE, in_AWID} = '0;
    {in_WVALID, in_WDATA, in_WSTRB, in_WLAST, in_BREADY} = '0;
    {in_ARVALID, in_ARADDR, in_ARBURST, in_ARLEN, in_ARSIZE, in_ARID, in_RREADY} = '0;
    {out_AWREADY, out_WREADY, out_BVALID, out_BRESP, out_BID, out_ARREADY} = '0;
    {out_RVALID, out_RDATA, out_RLAST, out_RID, out_RRESP} = '0;

    repeat (2) @(negedge ap_clk);
    check("rst_rd", rd_outstanding, 0);
    check("rst_wr", wr_outstanding, 0);
    check("rst_err", err, 0);
    check("rst_idle", idle, 1);
    ap_rst_n = 1'b1;

    // Six back-to-back ARs into a limit of four
    out_ARREADY = 1'b1; in_ARVALID = 1'b1; in_ARADDR = 32'h0000_1000; in_ARID = 4'h5;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("ar_ready_fill", in_ARREADY, (i < 4) ? 1 : 0);
      if (i == 0) check("ar_addr_pass", out_ARADDR, 32'h0000_1000);
      if (i == 0) check("ar_id_pass", out_ARID, 4'h5);
      if (in_ARVALID && in_ARREADY) accepted++;
      @(negedge ap_clk);
    end
    check("ar_accepted", accepted, 4);
    check("rd_full_cnt", rd_outstanding, 4);
    check("ar_valid_gated", out_ARVALID, 0);
    check("not_idle", idle, 0);

    // Completion at full does not reopen the gate in the same cycle
    out_RVALID = 1'b1; out_RLAST = 1'b1; in_RREADY = 1'b1;
    out_RDATA = 32'hCAFE_0001; out_RID = 4'h5;
    #1;
    check("full_gate_hold", in_ARREADY, 0);
    check("r_valid_pass", in_RVALID, 1);
    check("r_data_pass", in_RDATA, 32'hCAFE_0001);
    check("r_id_pass", in_RID, 4'h5);
    @(negedge ap_clk);
    out_RVALID = 1'b0; out_RLAST = 1'b0;
    #1;
    check("rd_after_rlast", rd_outstanding, 3);
    check("ar_reopen", in_ARREADY, 1);
    @(negedge ap_clk);
    check("rd_refill", rd_outstanding, 4);
    in_ARVALID = 1'b0;

    // Down to 2, then simultaneous AR and R-last
    rlast_cycles(2);
    check("rd_two", rd_outstanding, 2);
    in_ARVALID = 1'b1;
    rlast_cycles(1);
    in_ARVALID = 1'b0;
    check("rd_simul", rd_outstanding, 2);
    check("err_simul", err, 0);

    rlast_cycles(2);
    check("rd_drain", rd_outstanding, 0);
    check("idle_drain", idle, 1);

    // RLAST offered but not accepted: no count change
    out_RVALID = 1'b1; out_RLAST = 1'b1; in_RREADY = 1'b0;
    #1;
    check("r_ready_pass", out_RREADY, 0);
    @(negedge ap_clk);
    out_RVALID = 1'b0; out_RLAST = 1'b0;
    check("rlast_stall_cnt", rd_outstanding, 0);
    check("rlast_stall_err", err, 0);

    // ARLEN = 7 burst, 8 beats, RLAST on the eighth only
    in_ARVALID = 1'b1; in_ARLEN = 8'd7;
    #1;
    check("ar_len_pass", out_ARLEN, 7);
    @(negedge ap_clk);
    in_ARVALID = 1'b0; in_ARLEN = 8'd0;
    check("burst_open", rd_outstanding, 1);
    for (int b = 1; b <= 8; b++) begin
      out_RVALID = 1'b1; out_RLAST = (b == 8); in_RREADY = 1'b1;
      @(negedge ap_clk);
      check("burst_beat_cnt", rd_outstanding, (b == 8) ? 0 : 1);
    end
    out_RVALID = 1'b0; out_RLAST = 1'b0;
    check("burst_idle", idle, 1);

    // W leads AW and is never gated
    in_WVALID = 1'b1; out_WREADY = 1'b1; in_WDATA = 32'h1234_5678; in_WSTRB = 4'hF;
    #1;
    check("w_valid_lead", out_WVALID, 1);
    check("w_ready_lead", in_WREADY, 1);
    check("w_data_pass", out_WDATA, 32'h1234_5678);
    in_WVALID = 1'b0;

    // Five AWs into a limit of four
    @(negedge ap_clk);
    out_AWREADY = 1'b1; in_AWVALID = 1'b1; in_AWADDR = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("aw_ready_fill", in_AWREADY, (i < 4) ? 1 : 0);
      @(negedge ap_clk);
    end
    check("wr_full_cnt", wr_outstanding, 4);
    check("aw_valid_gated", out_AWVALID, 0);
    in_WVALID = 1'b1; out_WREADY = 1'b0;
    #1;
    check("w_ready_at_full", in_WREADY, 0);
    check("w_valid_at_full", out_WVALID, 1);
    in_AWVALID = 1'b0; in_WVALID = 1'b0;

    // B offered but not accepted
    @(negedge ap_clk);
    out_BVALID = 1'b1; out_BRESP = 2'b10; in_BREADY = 1'b0;
    #1;
    check("b_resp_pass", in_BRESP, 2'b10);
    check("b_ready_pass", out_BREADY, 0);
    @(negedge ap_clk);
    check("b_stall_cnt", wr_outstanding, 4);
    in_BREADY = 1'b1;
    repeat (4) @(negedge ap_clk);
    check("wr_drain", wr_outstanding, 0);

    // B handshake at zero: underflow, sticky
    @(negedge ap_clk);
    out_BVALID = 1'b0;
    check("b_underflow_err", err, 1);
    check("b_underflow_cnt", wr_outstanding, 0);
    repeat (3) @(negedge ap_clk);
    check("err_sticky", err, 1);

    // Reset mid-burst clears everything without waiting for a clock edge
    in_ARVALID = 1'b1;
    @(negedge ap_clk);
    in_ARVALID = 1'b0;
    check("pre_rst_rd", rd_outstanding, 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("async_rst_rd", rd_outstanding, 0);
    check("async_rst_err", err, 0);
    check("async_rst_idle", idle, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("post_rst_err", err, 0);
    check("post_rst_rd", rd_outstanding, 0);

    // Random traffic with random stalls; model counts bursts from the bench side
    rmodel = 0; wmodel = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge ap_clk);
      check("rnd_rd_cnt", rd_outstanding, rmodel);
      check("rnd_wr_cnt", wr_outstanding, wmodel);
      in_ARVALID  = 1'($urandom_range(0, 1));
      out_ARREADY = 1'($urandom_range(0, 1));
      out_RVALID  = (rmodel > 0) && ($urandom_range(0, 1) == 1);
      out_RLAST   = 1'b1;
      in_RREADY   = 1'($urandom_range(0, 1));
      out_RDATA   = $urandom;
      in_AWVALID  = 1'($urandom_range(0, 1));
      out_AWREADY = 1'($urandom_range(0, 1));
      out_BVALID  = (wmodel > 0) && ($urandom_range(0, 1) == 1);
      in_BREADY   = 1'($urandom_range(0, 1));
      in_WVALID   = 1'($urandom_range(0, 1));
      out_WREADY  = 1'($urandom_range(0, 1));
      in_WDATA    = $urandom;
      #1;
      check("rnd_ar_valid", out_ARVALID, in_ARVALID && (rmodel != c_MAX));
      check("rnd_ar_ready", in_ARREADY, out_ARREADY && (rmodel != c_MAX));
      check("rnd_aw_valid", out_AWVALID, in_AWVALID && (wmodel != c_MAX));
      check("rnd_rdata", in_RDATA, out_RDATA);
      check("rnd_wdata", out_WDATA, in_WDATA);
      ar_hs = in_ARVALID && out_ARREADY && (rmodel != c_MAX);
      aw_hs = in_AWVALID && out_AWREADY && (wmodel != c_MAX);
      r_hs  = out_RVALID && in_RREADY;
      b_hs  = out_BVALID && in_BREADY;
      rmodel = rmodel + int'(ar_hs) - int'(r_hs);
      wmodel = wmodel + int'(aw_hs) - int'(b_hs);
    end

    // Drain whatever is left
    for (int c = 0; c < 20; c++) begin
      @(negedge ap_clk);
      in_ARVALID = 1'b0; in_AWVALID = 1'b0; in_WVALID = 1'b0;
      out_RVALID = (rmodel > 0); out_RLAST = 1'b1; in_RREADY = 1'b1;
      out_BVALID = (wmodel > 0); in_BREADY = 1'b1;
      #1;
      if (out_RVALID) rmodel--;
      if (out_BVALID) wmodel--;
    end
    @(negedge ap_clk);
    out_RVALID = 1'b0; out_BVALID = 1'b0;
    check("final_rd", rd_outstanding, 0);
    check("final_wr", wr_outstanding, 0);
    check("final_idle", idle, 1);
    check("final_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
